// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-serial ALU sequencer: FSM states,
// ALU function codes, byte width and the latched request control word.
package alu_seq_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [1:0] alu_fn_t;

   // Function codes as understood by the 8-bit ALU.
   localparam alu_fn_t ADD_FN = 2'd0;
   localparam alu_fn_t AND_FN = 2'd1;
   localparam alu_fn_t OR_FN  = 2'd2;

   // Control captured at the accept edge. cin0 is the carry into byte 0
   // (use_c AND the flag_c snapshot); it only reaches the ALU for ADD.
   typedef struct packed {
      alu_fn_t op;
      logic    cin0;
   } req_ctrl_t;

   // The unused fourth code behaves as AND.
   function automatic alu_fn_t norm_fn(input alu_fn_t fn);
      return (fn == ADD_FN || fn == OR_FN) ? fn : AND_FN;
   endfunction

endpackage

// File: rtl/alu_byte_sequencer_if.sv
// Request/response handshake bundle for alu_byte_sequencer.
// master = requester/consumer side, slave = sequencer side.
interface alu_byte_sequencer_if
   import alu_seq_pkg::*;
#(
   parameter int N_BYTES = 2
);

   localparam int W = BYTE_W * N_BYTES;

   logic          req_valid;
   logic          req_ready;
   alu_fn_t       req_op;
   logic          req_use_c;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_result;

   modport master (
      output req_valid, req_op, req_use_c, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result
   );

   modport slave (
      input  req_valid, req_op, req_use_c, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result
   );

endinterface

// File: rtl/alu_status_reg.sv
// Architectural C/Z/N status register. Z and N load whenever an operation
// completes; C loads only when the completing operation produced a carry
// (ADD). Kept standalone so the branch unit can reuse it.
module alu_status_reg (
   input  logic clk,
   input  logic rst_n,
   input  logic upd_en,
   input  logic c_upd_en,
   input  logic c_next,
   input  logic z_next,
   input  logic n_next,
   output logic flag_c,
   output logic flag_z,
   output logic flag_n
);

   // Flag update on operation completion; C is held for logical ops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_c <= 1'b0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (upd_en) begin
         flag_z <= z_next;
         flag_n <= n_next;
         if (c_upd_en) begin
            flag_c <= c_next;
         end
      end
   end

endmodule

// File: rtl/alu_byte_sequencer.sv
// Multicycle front/back end around the 8-bit ALU. Accepts one W-bit
// request, feeds the ALU one byte per cycle LSB first with the carry
// chained between bytes, assembles the result, updates C/Z/N and holds
// the response until it is taken.
// Optional build macro: ALU_SEQ_BACK2BACK_EN -- accept the next request in
// DONE on the same edge the response is taken, removing the IDLE bubble.
module alu_byte_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N_BYTES = 2
)(
   input  logic               clk,
   input  logic               rst_n,
   alu_byte_sequencer_if.slave bus,
   output logic [BYTE_W-1:0]  alu_in1,
   output logic [BYTE_W-1:0]  alu_in2,
   output logic               alu_c_in,
   output alu_fn_t            alu_opcode,
   input  logic [BYTE_W-1:0]  alu_out,
   input  logic               alu_c_out,
   input  logic               alu_z_out,
   output logic               flag_c,
   output logic               flag_z,
   output logic               flag_n,
   output logic               busy
);

   localparam int W = BYTE_W * N_BYTES;

   typedef logic [2:0] cnt_t;
   localparam cnt_t LAST_BYTE = cnt_t'(N_BYTES - 1);

   state_t        state_q, state_d;
   cnt_t          cnt_q;
   req_ctrl_t     ctrl_q;
   logic [W-1:0]  a_q, b_q;
   logic [W-1:0]  res_q, res_d;
   logic [W-1:0]  rsp_result_q;
   logic          chain_c_q;
   logic          zacc_q;
   logic          accept;
   logic          last_byte;
   logic          byte_z;

   // Request port opens in IDLE, and optionally in DONE as the response drains.
   always_comb begin
      bus.req_ready = (state_q == IDLE);
`ifdef ALU_SEQ_BACK2BACK_EN
      if (state_q == DONE && bus.rsp_ready) begin
         bus.req_ready = 1'b1;
      end
`else
`endif
   end

   assign accept    = bus.req_valid & bus.req_ready;
   assign last_byte = (state_q == EXEC) && (cnt_q == LAST_BYTE);
   assign byte_z    = zacc_q & alu_z_out;

   // Next-state logic for the IDLE -> EXEC -> DONE sequence.
   always_comb begin
      // NOTE: every combinational output gets a default before the case so
      // no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = EXEC;
         EXEC: if (last_byte) state_d = DONE;
         DONE: if (bus.rsp_ready) state_d = accept ? EXEC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Drive byte k of each operand and the chained carry into the ALU.
   always_comb begin
      alu_in1    = '0;
      alu_in2    = '0;
      alu_c_in   = 1'b0;
      alu_opcode = ADD_FN;
      if (state_q == EXEC) begin
         alu_opcode = ctrl_q.op;
         for (int i = 0; i < N_BYTES; i++) begin
            if (cnt_q == cnt_t'(i)) begin
               alu_in1 = a_q[i*BYTE_W +: BYTE_W];
               alu_in2 = b_q[i*BYTE_W +: BYTE_W];
            end
         end
         if (ctrl_q.op == ADD_FN) begin
            alu_c_in = (cnt_q == '0) ? ctrl_q.cin0 : chain_c_q;
         end
      end
   end

   // Merge the current ALU byte into the partial result.
   always_comb begin
      res_d = res_q;
      for (int i = 0; i < N_BYTES; i++) begin
         if (cnt_q == cnt_t'(i)) begin
            res_d[i*BYTE_W +: BYTE_W] = alu_out;
         end
      end
   end

   // State, byte counter, carry chain, zero accumulator and response register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         ctrl_q       <= '0;
         chain_c_q    <= 1'b0;
         zacc_q       <= 1'b0;
         rsp_result_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q       <= '0;
            ctrl_q.op   <= norm_fn(bus.req_op);
            ctrl_q.cin0 <= bus.req_use_c & flag_c;
            zacc_q      <= 1'b1;
         end else if (state_q == EXEC) begin
            cnt_q     <= cnt_q + cnt_t'(1);
            chain_c_q <= alu_c_out;
            zacc_q    <= byte_z;
            if (last_byte) begin
               rsp_result_q <= res_d;
            end
         end
      end
   end

   // Operand latches and partial result.
   always_ff @(posedge clk) begin
      // NOTE: pure datapath registers carry no reset; they are always written
      // (at accept, or byte by byte in EXEC) before they are read.
      if (accept) begin
         a_q <= bus.req_a;
         b_q <= bus.req_b;
      end
      if (state_q == EXEC) begin
         res_q <= res_d;
      end
   end

   alu_status_reg u_status (
      .clk      (clk),
      .rst_n    (rst_n),
      .upd_en   (last_byte),
      .c_upd_en (ctrl_q.op == ADD_FN),
      .c_next   (alu_c_out),
      .z_next   (byte_z),
      .n_next   (alu_out[BYTE_W-1]),
      .flag_c   (flag_c),
      .flag_z   (flag_z),
      .flag_n   (flag_n)
   );

   assign bus.rsp_valid  = (state_q == DONE);
   assign bus.rsp_result = rsp_result_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Self-checking bench for alu_byte_sequencer (N_BYTES=2). Provides the 8-bit
// ALU as a combinational model, keeps a word-level reference of the
// sequencer, compares every cycle, and adds hand-computed directed checks.
module tb_alu_byte_sequencer;
   import alu_seq_pkg::*;

   localparam int N_BYTES = 2;
   localparam int W       = 8 * N_BYTES;
`ifdef ALU_SEQ_BACK2BACK_EN
   localparam bit B2B     = 1'b1;
   localparam int B2B_GAP = 3;
`else
   localparam bit B2B     = 1'b0;
   localparam int B2B_GAP = 4;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] alu_in1, alu_in2, alu_out;
   logic       alu_c_in, alu_c_out, alu_z_out;
   alu_fn_t    alu_opcode;
   logic       flag_c, flag_z, flag_n, busy;
   bit         cmp_en = 1'b0;
   int         cyc = 0;
   int         hs_q[$];
   int         checks = 0;
   int         failures = 0;

   initial forever #5 clk = ~clk;

   alu_byte_sequencer_if #(.N_BYTES(N_BYTES)) bus ();

   alu_byte_sequencer #(.N_BYTES(N_BYTES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_c_in   (alu_c_in),
      .alu_opcode (alu_opcode),
      .alu_out    (alu_out),
      .alu_c_out  (alu_c_out),
      .alu_z_out  (alu_z_out),
      .flag_c     (flag_c),
      .flag_z     (flag_z),
      .flag_n     (flag_n),
      .busy       (busy)
   );

   // The 8-bit ALU the sequencer drives.
   always_comb begin
      alu_out   = '0;
      alu_c_out = 1'b0;
      case (alu_opcode)
         ADD_FN:  {alu_c_out, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'd0, alu_c_in};
         OR_FN:   alu_out = alu_in1 | alu_in2;
         default: alu_out = alu_in1 & alu_in2;
      endcase
      alu_z_out = (alu_out == 8'd0);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- word-level reference model ----------------
   typedef enum int {M_IDLE, M_EXEC, M_DONE} m_state_t;

   m_state_t     m_st;
   int           m_k;
   logic [W-1:0] m_a, m_b, m_res;
   alu_fn_t      m_op;
   logic         m_cin0, m_c, m_z, m_n;
   logic         exp_rr, m_accept;
   logic [W:0]   m_full;
   logic [7:0]   e_in1, e_in2;
   logic         e_cin;
   alu_fn_t      e_opc;

   function automatic alu_fn_t model_fn(input alu_fn_t f);
      if (f == ADD_FN) return ADD_FN;
      if (f == OR_FN)  return OR_FN;
      return AND_FN;
   endfunction

   function automatic logic [W:0] model_op(input alu_fn_t f, input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
      if (f == ADD_FN) return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      if (f == OR_FN)  return {1'b0, a | b};
      return {1'b0, a & b};
   endfunction

   // Carry into byte k of a full-width add = bit 8k of the sum of the low 8k bits.
   function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int k);
      logic [63:0] m, s;
      m = (64'd1 << (8 * k)) - 64'd1;
      s = (64'(a) & m) + (64'(b) & m) + 64'(cin);
      return s[8*k];
   endfunction

   assign exp_rr   = (m_st == M_IDLE) || (B2B && m_st == M_DONE && bus.rsp_ready);
   assign m_accept = bus.req_valid && exp_rr;
   assign m_full   = model_op(m_op, m_a, m_b, m_cin0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st   <= M_IDLE;
         m_k    <= 0;
         m_a    <= '0;
         m_b    <= '0;
         m_res  <= '0;
         m_op   <= ADD_FN;
         m_cin0 <= 1'b0;
         m_c    <= 1'b0;
         m_z    <= 1'b0;
         m_n    <= 1'b0;
      end else begin
         if (m_st == M_EXEC) begin
            if (m_k == N_BYTES - 1) begin
               m_st  <= M_DONE;
               m_res <= m_full[W-1:0];
               m_z   <= (m_full[W-1:0] == '0);
               m_n   <= m_full[W-1];
               if (m_op == ADD_FN) m_c <= m_full[W];
            end else begin
               m_k <= m_k + 1;
            end
         end
         if (m_st == M_DONE && bus.rsp_ready) m_st <= M_IDLE;
         if (m_accept) begin
            m_st   <= M_EXEC;
            m_k    <= 0;
            m_a    <= bus.req_a;
            m_b    <= bus.req_b;
            m_op   <= model_fn(bus.req_op);
            m_cin0 <= bus.req_use_c & m_c;
         end
      end
   end

   always_comb begin
      e_in1 = '0;
      e_in2 = '0;
      e_cin = 1'b0;
      e_opc = ADD_FN;
      if (m_st == M_EXEC) begin
         e_in1 = 8'(m_a >> (8 * m_k));
         e_in2 = 8'(m_b >> (8 * m_k));
         e_opc = m_op;
         if (m_op == ADD_FN) e_cin = (m_k == 0) ? m_cin0 : carry_into(m_a, m_b, m_cin0, m_k);
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("handshake", 64'({bus.req_ready, bus.rsp_valid, busy}),
               64'({exp_rr, m_st == M_DONE, m_st != M_IDLE}));
         check("rsp_result", 64'(bus.rsp_result), 64'(m_res));
         check("flags", 64'({flag_c, flag_z, flag_n}), 64'({m_c, m_z, m_n}));
         check("alu_drive", 64'({alu_in1, alu_in2, alu_c_in, alu_opcode}), 64'({e_in1, e_in2, e_cin, e_opc}));
      end
   end

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.rsp_valid && bus.rsp_ready) hs_q.push_back(cyc);

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Present a request just after an edge, hold it until accepted; returns
   // #1 after the accept edge. keep=1 leaves req_valid asserted.
   task automatic send(input alu_fn_t op, input logic uc, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit keep);
      bit ok;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_use_c = uc;
      bus.req_a     = a;
      bus.req_b     = b;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         ok = bus.req_ready;
         @(posedge clk);
         #1;
         if (ok) break;
         if (n == 49) check("accept_timeout", 64'd0, 64'd1);
      end
      if (!keep) begin
         bus.req_valid = 1'b0;
         bus.req_op    = alu_fn_t'($urandom_range(0, 3));
         bus.req_use_c = 1'($urandom_range(0, 1));
         bus.req_a     = W'($urandom);
         bus.req_b     = W'($urandom);
      end
   endtask

   // Wait for rsp_valid; lat counts cycles after the accepting cycle.
   task automatic wait_rsp(output logic [W-1:0] res, output logic [2:0] flg, output int lat, output logic cin_k1);
      lat = -1;
      res = '0;
      flg = '0;
      cin_k1 = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 2) cin_k1 = alu_c_in;
         if (bus.rsp_valid) begin
            lat = i;
            res = bus.rsp_result;
            flg = {flag_c, flag_z, flag_n};
            break;
         end
      end
      if (lat < 0) check("rsp_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 4))
         0:       return '0;
         1:       return '1;
         2:       return W'(1);
         default: return W'($urandom);
      endcase
   endfunction

   // ---------------- test sequence ----------------
   initial begin : stim
      logic [W-1:0] res;
      logic [2:0]   flg;
      int           lat;
      logic         c1;
      int           seen;

      bus.req_valid = 1'b0;
      bus.req_op    = ADD_FN;
      bus.req_use_c = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;

      repeat (2) @(posedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      check("reset_hs", 64'({bus.req_ready, bus.rsp_valid, busy}), 64'(3'b100));
      check("reset_out", 64'({bus.rsp_result, flag_c, flag_z, flag_n}), 64'd0);
      check("reset_alu", 64'({alu_in1, alu_in2, alu_c_in, alu_opcode}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 0x12FF + 0x0001
      send(ADD_FN, 1'b0, 16'h12FF, 16'h0001, 1'b0);
      wait_rsp(res, flg, lat, c1);
      check("add1_result", 64'(res), 64'h1300);
      check("add1_flags", 64'(flg), 64'(3'b000));
      check("add1_latency", 64'(lat), 64'd3);
      check("add1_chain_cin", 64'(c1), 64'd1);

      // 0xFFFF + 1 wraps, then ADC 0 + 0 picks up C
      send(ADD_FN, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      wait_rsp(res, flg, lat, c1);
      check("wrap_result", 64'(res), 64'h0000);
      check("wrap_flags", 64'(flg), 64'(3'b110));
      send(ADD_FN, 1'b1, 16'h0000, 16'h0000, 1'b0);
      wait_rsp(res, flg, lat, c1);
      check("adc_result", 64'(res), 64'h0001);
      check("adc_flags", 64'(flg), 64'(3'b000));

      // Logical ops keep C
      send(ADD_FN, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      wait_rsp(res, flg, lat, c1);
      send(AND_FN, 1'b0, 16'h8F0F, 16'hF0FF, 1'b0);
      wait_rsp(res, flg, lat, c1);
      check("and_result", 64'(res), 64'h800F);
      check("and_flags", 64'(flg), 64'(3'b101));
      send(OR_FN, 1'b0, 16'h0100, 16'h0000, 1'b0);
      wait_rsp(res, flg, lat, c1);
      check("or_result", 64'(res), 64'h0100);
      check("or_flags", 64'(flg), 64'(3'b100));

      // Back-pressure
      bus.rsp_ready = 1'b0;
      send(ADD_FN, 1'b0, 16'h0001, 16'h0002, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) break;
         if (i == 19) check("bp_timeout", 64'd0, 64'd1);
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = OR_FN;
      bus.req_a     = 16'hAAAA;
      bus.req_b     = 16'h5555;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_result}), 64'({1'b0, 1'b1, 16'h0003}));
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_release", 64'({bus.req_ready, bus.rsp_valid, busy}), 64'(3'b100));
      @(posedge clk);
      #1;

      // Reset in EXEC after byte 0
      send(ADD_FN, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      wait_rsp(res, flg, lat, c1);
      check("pre_reset_flags", 64'(flg), 64'(3'b110));
      send(ADD_FN, 1'b0, 16'h1234, 16'h1111, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_hs", 64'({bus.req_ready, bus.rsp_valid, busy}), 64'(3'b100));
      check("rst_out", 64'({bus.rsp_result, flag_c, flag_z, flag_n}), 64'd0);
      check("rst_alu", 64'({alu_in1, alu_in2, alu_c_in, alu_opcode}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid || busy) seen++;
      end
      check("no_rsp_after_reset", 64'(seen), 64'd0);
      @(posedge clk);
      #1;

      // Back-to-back throughput
      hs_q.delete();
      send(ADD_FN, 1'b0, 16'h0001, 16'h0002, 1'b1);
      send(ADD_FN, 1'b0, 16'h0010, 16'h0020, 1'b0);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         if (hs_q.size() >= 2) break;
      end
      #1;
      if (hs_q.size() >= 2) check("b2b_gap", 64'(hs_q[1] - hs_q[0]), 64'(B2B_GAP));
      else check("b2b_timeout", 64'(hs_q.size()), 64'd2);

      // Randomized operations with idle gaps and response stalls
      for (int t = 0; t < 150; t++) begin
         int stall;
         stall = $urandom_range(0, 3);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         if (stall > 0) bus.rsp_ready = 1'b0;
         send(alu_fn_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 1'b0);
         wait_rsp(res, flg, lat, c1);
         repeat (stall) begin
            @(posedge clk);
            #1;
         end
         if (stall > 0) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
         end
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
